// File: rtl/data_island_packet_scheduler.sv
// Data-island packet slot scheduler: picks the HB0 packet type for each slot.
// Optional SPD InfoFrame scheduling is enabled by defining SPD_INFOFRAME_EN.
//
// Ports:
//   clk_pixel, reset_n          pixel clock, async active-low reset
//   packet_enable               one-cycle pulse at the start of a packet slot
//   clk_audio_counter_wrap      toggle from the ACR generator; each change = one ACR request
//   audio_packet_ready          level, an audio sample packet is available
//   frame_start                 one-cycle pulse per frame, requests InfoFrames
//   packet_type[7:0]            HB0 of the selected packet, held between slots
//   audio_packet_ack            one-cycle pulse when an audio sample packet is consumed
//   acr_overrun                 sticky, ACR request arrived while one was still pending
module data_island_packet_scheduler #(
    parameter int unsigned MAX_AUDIO_BURST = 4
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       packet_enable,
    input  logic       clk_audio_counter_wrap,
    input  logic       audio_packet_ready,
    input  logic       frame_start,
    output logic [7:0] packet_type,
    output logic       audio_packet_ack,
    output logic       acr_overrun
);

    localparam logic [7:0] PT_NULL  = 8'h00;
    localparam logic [7:0] PT_ACR   = 8'h01;
    localparam logic [7:0] PT_AUDIO = 8'h02;
    localparam logic [7:0] PT_AVI   = 8'h82;
`ifdef SPD_INFOFRAME_EN
    localparam logic [7:0] PT_SPD   = 8'h83;
`endif
    localparam logic [7:0] PT_AIF   = 8'h84;

    localparam logic [3:0] BURST_MAX = 4'(MAX_AUDIO_BURST);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t     state_q, state_d;
    logic       wrap_q;
    logic       acr_pending_q, acr_pending_d;
    logic       avi_pending_q, avi_pending_d;
    logic       aif_pending_q, aif_pending_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] packet_type_q, packet_type_d;
    logic       audio_ack_q, audio_ack_d;
    logic       acr_overrun_q, acr_overrun_d;

    logic       spd_req;
`ifdef SPD_INFOFRAME_EN
    logic       spd_pending_q, spd_pending_d;
    assign spd_req = spd_pending_q;
`else
    assign spd_req = 1'b0;
`endif

    logic acr_event;
    logic any_if_pending;
    logic issue;
    logic sel_acr, sel_audio, sel_avi, sel_aif, sel_spd;

    always_comb begin
        state_d       = state_q;
        acr_pending_d = acr_pending_q;
        avi_pending_d = avi_pending_q;
        aif_pending_d = aif_pending_q;
        burst_cnt_d   = burst_cnt_q;
        packet_type_d = packet_type_q;
        audio_ack_d   = 1'b0;
        acr_overrun_d = acr_overrun_q;
        sel_acr       = 1'b0;
        sel_audio     = 1'b0;
        sel_avi       = 1'b0;
        sel_aif       = 1'b0;
        sel_spd       = 1'b0;
`ifdef SPD_INFOFRAME_EN
        spd_pending_d = spd_pending_q;
`endif

        acr_event      = clk_audio_counter_wrap ^ wrap_q;
        any_if_pending = avi_pending_q | aif_pending_q | spd_req;
        issue          = (state_q == IDLE) && packet_enable;

        // Selection looks only at pending state held before this cycle's
        // set events, so a same-cycle request waits for the next slot.
        if (issue) begin
            if (acr_pending_q) begin
                sel_acr = 1'b1;
            end else if (audio_packet_ready && (burst_cnt_q < BURST_MAX)) begin
                sel_audio = 1'b1;
            end else if (avi_pending_q) begin
                sel_avi = 1'b1;
            end else if (aif_pending_q) begin
                sel_aif = 1'b1;
            end else if (spd_req) begin
                sel_spd = 1'b1;
            end else if (audio_packet_ready && !any_if_pending) begin
                sel_audio = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            unique case (1'b1)
                sel_acr:   packet_type_d = PT_ACR;
                sel_audio: packet_type_d = PT_AUDIO;
                sel_avi:   packet_type_d = PT_AVI;
                sel_aif:   packet_type_d = PT_AIF;
`ifdef SPD_INFOFRAME_EN
                sel_spd:   packet_type_d = PT_SPD;
`endif
                default:   packet_type_d = PT_NULL;
            endcase
            audio_ack_d = sel_audio;
        end

        // Clear on selection, then OR in new requests so set wins.
        acr_pending_d = (acr_pending_q & ~sel_acr) | acr_event;
        avi_pending_d = (avi_pending_q & ~sel_avi) | frame_start;
        aif_pending_d = (aif_pending_q & ~sel_aif) | frame_start;
`ifdef SPD_INFOFRAME_EN
        spd_pending_d = (spd_pending_q & ~sel_spd) | frame_start;
`endif

        if (issue) begin
            if (sel_audio && any_if_pending) begin
                if (burst_cnt_q < BURST_MAX) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end else begin
                burst_cnt_d = 4'd0;
            end
        end else if (!any_if_pending) begin
            burst_cnt_d = 4'd0;
        end

        if (acr_event && acr_pending_q && !sel_acr) begin
            acr_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wrap_q        <= 1'b0;
            acr_pending_q <= 1'b0;
            avi_pending_q <= 1'b0;
            aif_pending_q <= 1'b0;
            burst_cnt_q   <= 4'd0;
            packet_type_q <= PT_NULL;
            audio_ack_q   <= 1'b0;
            acr_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wrap_q        <= clk_audio_counter_wrap;
            acr_pending_q <= acr_pending_d;
            avi_pending_q <= avi_pending_d;
            aif_pending_q <= aif_pending_d;
            burst_cnt_q   <= burst_cnt_d;
            packet_type_q <= packet_type_d;
            audio_ack_q   <= audio_ack_d;
            acr_overrun_q <= acr_overrun_d;
        end
    end

`ifdef SPD_INFOFRAME_EN
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            spd_pending_q <= 1'b0;
        end else begin
            spd_pending_q <= spd_pending_d;
        end
    end
`endif

    assign packet_type      = packet_type_q;
    assign audio_packet_ack = audio_ack_q;
    assign acr_overrun      = acr_overrun_q;

endmodule

// File: doc/data_island_packet_scheduler.md
# data_island_packet_scheduler

Picks which packet type occupies each data-island packet slot on the pixel clock. Consumes the toggle-style `clk_audio_counter_wrap` from the audio clock regeneration packet generator, the audio sample packet readiness flag, and a frame-start strobe. It drives the packet type select and the acknowledge signals to the packet sources. Its output feeds the packet assembler's header/subpacket mux.

## Interface
Parameters:
- `MAX_AUDIO_BURST`, default 4: consecutive audio sample packets allowed while an InfoFrame is pending; range 1–15.

Ports:
- `clk_pixel`  in  1  pixel clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `packet_enable`  in  1  one-cycle pulse marking the start of a new 32-cycle packet slot.
- `clk_audio_counter_wrap`  in  1  toggle from the ACR generator, already in the `clk_pixel` domain; each change requests one ACR packet.
- `audio_packet_ready`  in  1  level; an audio sample packet is available.
- `frame_start`  in  1  one-cycle pulse once per frame.
- `packet_type`  out  8  HB0 of the selected packet; held between slots.
- `audio_packet_ack`  out  1  one-cycle pulse; the audio sample packet has been consumed.
- `acr_overrun`  out  1  sticky; an ACR request arrived while one was still pending.

## Operation
- Packet type codes:
  - 0x00 null
  - 0x01 ACR
  - 0x02 audio sample
  - 0x82 AVI InfoFrame
  - 0x83 SPD InfoFrame
  - 0x84 audio InfoFrame
- ACR request detection:
  - Register `clk_audio_counter_wrap` into `wrap_q`.
  - `acr_event = wrap ^ wrap_q`.
  - An `acr_event` sets `acr_pending`.
- InfoFrame requests: `frame_start` sets `avi_pending`, `aif_pending` and, with the macro, `spd_pending`.
- Priority on `packet_enable` is evaluated on the pending state before this cycle's set events:
  1. ACR.
  2. Audio sample, if `audio_packet_ready` and `burst_cnt < MAX_AUDIO_BURST`.
  3. AVI.
  4. Audio InfoFrame.
  5. SPD.
  6. Audio sample (burst limit reached, but no InfoFrame is pending).
  7. Null.
- Selecting a pending type clears that pending bit.
- Same-cycle set and clear of one bit: set wins, so the request is kept for the next slot.
- `burst_cnt` (4 bits):
  - Increments when an audio sample is selected while any InfoFrame is pending.
  - Clears on any non-audio selection, or when no InfoFrame is pending.
  - Saturates at `MAX_AUDIO_BURST`.
- `acr_overrun` sets when `acr_event` occurs with `acr_pending` already 1 and not being cleared this cycle. It clears only on reset.
- State machine:
  - `IDLE`: waits for `packet_enable`.
  - `ISSUE`: one cycle; updates `packet_type` and pulses ack.
  - Returns to `IDLE`.
  - A `packet_enable` arriving in `ISSUE` is ignored; slots are at least 32 cycles apart by contract.

## Timing
- Reset values:
  - `packet_type` = 0x00
  - `audio_packet_ack` = 0
  - `acr_overrun` = 0
  - all pending bits = 0
  - `burst_cnt` = 0
  - `wrap_q` = 0
  - state = `IDLE`
- Reset assertion takes effect immediately. All pending requests are discarded.
- `packet_enable` in cycle t gives `packet_type` valid from t+1. It is held until the next issue.
- `audio_packet_ack` is high only in cycle t+1. The source must not deassert `audio_packet_ready` before the ack.
- An `acr_event` in cycle t is eligible for a slot whose `packet_enable` is in cycle t+1 or later.
- `frame_start` and `packet_enable` in the same cycle: the InfoFrames are pending from the next slot.
- Reset deasserted with `clk_audio_counter_wrap` = 1: `wrap_q` starts at 0, so one ACR request is generated. This is intended; the sink gets an early N/CTS.

## Configuration
- `SPD_INFOFRAME_EN`:
  - Defined: `spd_pending` exists and SPD is scheduled once per frame at priority 5.
  - Undefined: no SPD logic; code 0x83 is never output.

## Test plan
- Reset, then `packet_enable` with no requests -> `packet_type` = 0x00 at t+1; no ack; `acr_overrun` = 0.
- Toggle `clk_audio_counter_wrap` while `audio_packet_ready` = 1, then `packet_enable` -> 0x01; next slot -> 0x02 with a single-cycle ack.
- `frame_start`, `audio_packet_ready` held 1, default parameter, 6 slots -> 0x02, 0x02, 0x02, 0x02, 0x82, 0x02.
- Toggle the wrap twice with no slot between -> `acr_overrun` = 1 and stays 1; one slot -> 0x01; next slot -> 0x00.
- `frame_start` with the macro defined, no audio -> 0x82, 0x84, 0x83, 0x00; with the macro undefined -> 0x82, 0x84, 0x00.
- Assert `reset_n` low mid-frame with AVI pending -> `packet_type` = 0x00 immediately; next slot after release -> 0x00.
